// File: rtl/pipe_stage_latch_pkg.sv
// Shared types and constants for the pipeline-stage register.
package pipe_stage_latch_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b10
    } state_e;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_NUM_CH = 4;

    localparam logic [31:0] NOP_ENC = 32'h0000_0000;

    localparam int unsigned CH_PC  = 0;
    localparam int unsigned CH_A   = 1;
    localparam int unsigned CH_B   = 2;
    localparam int unsigned CH_INS = 3;

endpackage

// File: rtl/pipe_stage_latch_reg.sv
// Enabled data register with a synchronous load-value reset.
module pipe_stage_latch_reg #(
    parameter int unsigned W = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] rst_val_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= rst_val_i;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_latch.sv
// Ready/valid pipeline-stage register with a 2-entry skid buffer and flush.
// Optional stall counter is built when PIPE_STAGE_LATCH_STALL_CNT_EN is defined.
module pipe_stage_latch
    import pipe_stage_latch_pkg::*;
#(
    parameter int unsigned       WIDTH     = DEF_WIDTH,
    parameter int unsigned       NUM_CH    = DEF_NUM_CH,
    parameter int unsigned       NOP_CH    = CH_INS,
    parameter logic [WIDTH-1:0]  NOP_VALUE = WIDTH'(NOP_ENC)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [31:0]             stall_cycles
);

    localparam int unsigned DW = NUM_CH * WIDTH;

    state_e          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            acc, drn;
    logic            main_en, skid_en;
    logic [DW-1:0]   main_d, main_q, skid_q;
    logic [DW-1:0]   rst_val;

    always_comb begin
        rst_val = '0;
        rst_val[NOP_CH*WIDTH +: WIDTH] = NOP_VALUE;
    end

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign acc       = in_valid & in_ready_q;
    assign drn       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        main_d  = in_data;
        skid_en = 1'b0;
        if (flush) begin
            // A same-cycle drain has already been consumed downstream; just empty.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = FULL;
                        main_en = 1'b1;
                    end
                end
                FULL: begin
                    if (acc && drn) begin
                        main_en = 1'b1;
                    end else if (acc) begin
                        state_d = SKID;
                        skid_en = 1'b1;
                    end else if (drn) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (drn) begin
                        state_d = FULL;
                        main_en = 1'b1;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != SKID);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    pipe_stage_latch_reg #(.W(DW)) u_main (
        .clk       (clk),
        .reset     (reset),
        .en_i      (main_en),
        .rst_val_i (rst_val),
        .d_i       (main_d),
        .q_o       (main_q)
    );

    pipe_stage_latch_reg #(.W(DW)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .en_i      (skid_en),
        .rst_val_i (rst_val),
        .d_i       (in_data),
        .q_o       (skid_q)
    );

    always_comb begin
        out_data = main_q;
        if (!out_valid) begin
            out_data[NOP_CH*WIDTH +: WIDTH] = NOP_VALUE;
        end
    end

`ifdef PIPE_STAGE_LATCH_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Self-checking bench for pipe_stage_latch: queue model plus directed literal checks.
module tb_pipe_stage_latch;
    import pipe_stage_latch_pkg::*;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int DW = W * N;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [31:0]   stall_cycles;

    always #5 clk = ~clk;

    pipe_stage_latch #(
        .WIDTH     (32),
        .NUM_CH    (4),
        .NOP_CH    (3),
        .NOP_VALUE (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .stall_cycles (stall_cycles)
    );

    function automatic logic [DW-1:0] ent(input logic [31:0] pc, a, b, ins);
        return {ins, b, a, pc};
    endfunction

    function automatic logic [31:0] sc(input logic [31:0] n);
`ifdef PIPE_STAGE_LATCH_STALL_CNT_EN
        return n;
`else
        return 32'd0;
`endif
    endfunction

    // Model: a 2-deep FIFO whose ready flag reflects occupancy after each edge.
    logic [DW-1:0] mq[$];
    bit            m_rdy;
    logic [31:0]   m_cnt;
    bit            pre_req = 1'b0, pre_done = 1'b0, cmp_en = 1'b0;

    always @(posedge clk) begin : model
        bit drn, acc;
        drn = (mq.size() != 0) && out_ready;
        acc = in_valid && m_rdy;
        if (reset) begin
            mq.delete();
            m_rdy = 1'b1;
            m_cnt = 32'd0;
        end else begin
            if (pre_req && !pre_done) begin
                m_cnt    = 32'hFFFF_FFFD;
                pre_done = 1'b1;
            end
            if ((mq.size() != 0) && !out_ready && (m_cnt != 32'hFFFF_FFFF))
                m_cnt = m_cnt + sc(32'd1);
            if (flush) begin
                mq.delete();
            end else begin
                if (drn) void'(mq.pop_front());
                if (acc) mq.push_back(in_data);
            end
            m_rdy = (mq.size() < 2);
        end
    end

    int n_cmp = 0, n_bad = 0;

    bit          lit_en = 1'b0;
    string       lit_name;
    bit          lit_v, lit_r, lit_cc;
    logic [31:0] lit_pc, lit_ins, lit_cnt;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        if (cmp_en) begin
            chk("model.out_valid", DW'(out_valid), DW'(mq.size() != 0));
            chk("model.in_ready", DW'(in_ready), DW'(m_rdy));
            chk("model.stall_cycles", DW'(stall_cycles), DW'(m_cnt));
            if (mq.size() != 0) chk("model.out_data", out_data, mq[0]);
            else                chk("model.bubble_nop", DW'(out_data[3*W +: W]), DW'(NOP_ENC));
        end
        if (lit_en) begin
            chk({lit_name, ".valid"}, DW'(out_valid), DW'(lit_v));
            chk({lit_name, ".ready"}, DW'(in_ready), DW'(lit_r));
            chk({lit_name, ".ins"}, DW'(out_data[3*W +: W]), DW'(lit_ins));
            if (lit_v)  chk({lit_name, ".pc"}, DW'(out_data[W-1:0]), DW'(lit_pc));
            if (lit_cc) chk({lit_name, ".stall"}, DW'(stall_cycles), DW'(lit_cnt));
        end
    end

    task automatic step(input bit v, input logic [DW-1:0] d, input bit fl,
                        input bit ordy, input bit rst);
        reset     = rst;
        in_valid  = v;
        in_data   = d;
        flush     = fl;
        out_ready = ordy;
        @(posedge clk);
        #1;
        lit_en = 1'b0;
    endtask

    task automatic expect_lit(input string name, input bit v, input bit r,
                              input logic [31:0] pc, input logic [31:0] ins,
                              input bit cc, input logic [31:0] cnt);
        lit_name = name;
        lit_v    = v;
        lit_r    = r;
        lit_pc   = pc;
        lit_ins  = ins;
        lit_cc   = cc;
        lit_cnt  = cnt;
        lit_en   = 1'b1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [DW-1:0] z;
        z = '0;

        step(0, z, 0, 0, 1);
        step(0, z, 0, 0, 1);
        cmp_en = 1'b1;
        step(0, z, 0, 0, 0);
        expect_lit("reset", 0, 1, 0, 32'h0, 1, 0);

        // Streaming at full rate
        for (int i = 0; i < 4; i++) begin
            step(1, ent(32'h10 + 4*i, 1 + i, 2 + i, 32'hABCD + i), 0, 1, 0);
            expect_lit("stream", 1, 1, 32'h10 + 4*i, 32'hABCD + i, 1, 0);
        end
        step(0, z, 0, 1, 0);
        expect_lit("stream_end", 0, 1, 0, 32'h0, 1, 0);

        // Back-pressure: two accepted, third held upstream
        step(1, ent(32'h10, 1, 2, 32'h1111), 0, 0, 0);
        expect_lit("bp_a", 1, 1, 32'h10, 32'h1111, 1, sc(0));
        step(1, ent(32'h14, 1, 2, 32'h2222), 0, 0, 0);
        expect_lit("bp_b", 1, 0, 32'h10, 32'h1111, 1, sc(1));
        step(1, ent(32'h18, 1, 2, 32'h3333), 0, 0, 0);
        expect_lit("bp_c", 1, 0, 32'h10, 32'h1111, 1, sc(2));
        step(1, ent(32'h18, 1, 2, 32'h3333), 0, 0, 0);
        expect_lit("bp_d", 1, 0, 32'h10, 32'h1111, 1, sc(3));
        step(1, ent(32'h18, 1, 2, 32'h3333), 0, 1, 0);
        expect_lit("bp_e", 1, 1, 32'h14, 32'h2222, 1, sc(3));
        step(1, ent(32'h18, 1, 2, 32'h3333), 0, 1, 0);
        expect_lit("bp_f", 1, 1, 32'h18, 32'h3333, 1, sc(3));
        step(0, z, 0, 1, 0);
        expect_lit("bp_g", 0, 1, 0, 32'h0, 1, sc(3));

        // Flush while holding two entries with a third incoming
        step(1, ent(32'h20, 0, 0, 32'h4444), 0, 0, 0);
        step(1, ent(32'h24, 0, 0, 32'h5555), 0, 0, 0);
        expect_lit("fs_fill", 1, 0, 32'h20, 32'h4444, 1, sc(4));
        step(1, ent(32'h28, 0, 0, 32'h6666), 1, 0, 0);
        expect_lit("fs_flush", 0, 1, 0, 32'h0, 1, sc(5));
        step(0, z, 0, 1, 0);
        expect_lit("fs_after1", 0, 1, 0, 32'h0, 0, 0);
        step(0, z, 0, 1, 0);
        expect_lit("fs_after2", 0, 1, 0, 32'h0, 0, 0);

        // Flush coinciding with a drain from FULL
        step(1, ent(32'h30, 0, 0, 32'h7777), 0, 1, 0);
        expect_lit("fd_full", 1, 1, 32'h30, 32'h7777, 0, 0);
        step(0, z, 1, 1, 0);
        expect_lit("fd_flush", 0, 1, 0, 32'h0, 1, sc(5));
        step(0, z, 0, 1, 0);
        expect_lit("fd_after", 0, 1, 0, 32'h0, 1, sc(5));

        // Reset in the middle of a stall with two entries held
        step(1, ent(32'h40, 0, 0, 32'h8888), 0, 0, 0);
        step(1, ent(32'h44, 0, 0, 32'h9999), 0, 0, 0);
        expect_lit("rs_fill", 1, 0, 32'h40, 32'h8888, 1, sc(6));
        step(1, ent(32'h48, 0, 0, 32'hAAAA), 0, 0, 1);
        expect_lit("rs_reset", 0, 1, 0, 32'h0, 1, 0);
        step(0, z, 0, 1, 0);

`ifdef PIPE_STAGE_LATCH_STALL_CNT_EN
        // Preload the counter near its ceiling and stall past it
        cmp_en = 1'b0;
        force dut.stall_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_q;
        pre_req = 1'b1;
        step(0, z, 0, 1, 0);
        cmp_en = 1'b1;
        expect_lit("sat_load", 0, 1, 0, 32'h0, 1, 32'hFFFF_FFFD);
        step(1, ent(32'h50, 0, 0, 32'hBBBB), 0, 0, 0);
        step(1, ent(32'h54, 0, 0, 32'hCCCC), 0, 0, 0);
        expect_lit("sat_fe", 1, 0, 32'h50, 32'hBBBB, 1, 32'hFFFF_FFFE);
        step(0, z, 0, 0, 0);
        expect_lit("sat_ff", 1, 0, 32'h50, 32'hBBBB, 1, 32'hFFFF_FFFF);
        step(0, z, 0, 0, 0);
        expect_lit("sat_hold", 1, 0, 32'h50, 32'hBBBB, 1, 32'hFFFF_FFFF);
`endif

        step(0, z, 0, 1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_latch.md
Name: pipe_stage_latch

Overview:
- Parametrised pipeline-stage register for the processor pipeline (F/D, D/X, X/M, M/W boundaries).
- Carries NUM_CH channels of WIDTH bits each, for example PC, A, B and instruction.
- Adds a ready/valid handshake with a 2-entry skid buffer, so stalls never combinationally cross the stage.
- Adds a synchronous flush that turns the stage into a bubble, with a NOP forced on the instruction channel.

Parameters:
- WIDTH, 32, bits per channel.
- NUM_CH, 4, number of channels; channel k occupies bits [k*WIDTH +: WIDTH].
- NOP_CH, 3, channel index that carries the instruction and is forced to NOP_VALUE on a bubble.
- NOP_VALUE, 32'h0000_0000, encoding driven on NOP_CH when out_valid=0.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents in_data.
- in_ready  out  1  stage can accept; driven from a register, not from out_ready.
- in_data  in  NUM_CH*WIDTH  packed channels.
- flush  in  1  squash all held and incoming entries (branch mispredict or jump).
- out_valid  out  1  out_data holds a live entry.
- out_ready  in  1  downstream accepts.
- out_data  out  NUM_CH*WIDTH  head entry.
- stall_cycles  out  32  back-pressure counter (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on `reset`.
- Storage: two entries, main and skid.
- State machine (3 states): EMPTY, FULL (main only), SKID (main and skid).
- Transfer definitions: acc = in_valid & in_ready; drn = out_valid & out_ready.
- EMPTY: acc → FULL, main<=in_data.
- FULL, acc & drn → FULL, main<=in_data.
- FULL, acc & !drn → SKID, skid<=in_data.
- FULL, !acc & drn → EMPTY.
- FULL, otherwise → hold.
- SKID: in_ready=0. drn → FULL, main<=skid. Otherwise → hold.
- Handshake signals:
  - in_ready = (state != SKID), registered.
  - out_valid = (state != EMPTY).
- Latency and throughput: 1 cycle in_data→out_data. Sustained 1 entry/cycle while out_ready=1.
- Ordering and stability: strict FIFO order. No entry is dropped or duplicated. out_data is stable while out_valid & !out_ready.
- Flush:
  - Priority: below reset, above all handshake events.
  - Next state is EMPTY. A same-cycle acc is discarded. A same-cycle drn still completes downstream; the entry is consumed and not repeated.
  - in_ready=1 on the following cycle.
- Bubble output: whenever out_valid=0, channel NOP_CH of out_data = NOP_VALUE. Other channels hold their last main contents (don't-care).
- Reset:
  - state=EMPTY, out_valid=0, in_ready=1 on the cycle after reset is sampled high.
  - main=skid=0, with NOP_CH = NOP_VALUE.
  - stall_cycles=0.
  - A reset mid-stall discards both entries.
- Width rules: channels are opaque. No arithmetic on data.

Optional Feature:
- Macro: PIPE_STAGE_LATCH_STALL_CNT_EN.
- Defined: stall_cycles increments each cycle with out_valid & !out_ready and saturates at 32'hFFFF_FFFF. It is cleared only by reset; flush does not clear it.
- Undefined: stall_cycles is tied to 0 and no counter logic is synthesised.

Decomposition:
- Package pipe_stage_latch_pkg holds:
  - State enum (EMPTY/FULL/SKID, 2-bit encoding).
  - Default WIDTH/NUM_CH constants.
  - Canonical NOP encoding.
  - Channel-index constants: CH_PC=0, CH_A=1, CH_B=2, CH_INS=3.
- Sub-module pipe_stage_latch_reg: a NUM_CH*WIDTH enabled register with synchronous load-value reset. It is instantiated twice (main, skid).

Test Plan:
- Reset → after 1 clk: out_valid=0, in_ready=1, out_data[NOP_CH]=NOP_VALUE, stall_cycles=0.
- Streaming, out_ready=1, entries {PC=0x10,A=1,B=2,INS=0xABCD} then PC=0x14… each cycle → each appears on out_data exactly 1 cycle later, no gaps.
- Back-pressure, out_ready=0, three entries offered (0x10, 0x14, 0x18) → first two accepted, in_ready=0 from cycle 3, 0x18 is held upstream. Release out_ready → order 0x10, 0x14, 0x18. stall_cycles equals the number of stalled valid cycles (macro on) or 0 (macro off).
- Flush while in SKID with in_valid=1 → next cycle out_valid=0, out_data[NOP_CH]=NOP_VALUE, in_ready=1. Neither held entry nor the incoming entry ever emerges.
- Flush in the same cycle as drn in FULL → the drained entry is seen once, then the stage is EMPTY.
- Reset asserted mid-stall with 2 entries held → EMPTY next cycle, stall_cycles=0. With the macro on, force stall_cycles near 2^32−1 → it saturates and does not wrap.
